l1_port_scheduler: RTL and testbench

Stateful two-port scheduler sharing the single L1 cache request port between instruction fetch and the data (load/store) path. Grants one requester at a time, holds the grant until the L1 signals completion, and routes the L1 response only to the granted side. Data has fixed priority, overridden by a starvation limit that guarantees forward progress for fetch. Sits between the IF/MEM pipeline stages and the L1 core.

---
 rtl/l1_port_scheduler.sv | 132 +++++++++++++
 tb/tb_l1_port_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/l1_port_scheduler.sv
// Shares the single L1 request port between instruction fetch and the data path.
// Data has fixed priority. A starvation limit lets fetch win a contested arbitration.
package l1_port_scheduler_pkg;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  typedef struct packed {
    logic        ready;
    logic        err;
    logic [31:0] rdata;
  } mem_resp_t;

endpackage

module l1_port_scheduler
  import l1_port_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned PERF_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  mem_req_t          if_req_i,
  output mem_resp_t         if_resp_o,
  input  mem_req_t          data_req_i,
  output mem_resp_t         data_resp_o,
  output mem_req_t          active_req_o,
  input  mem_resp_t         active_resp_i,
  output logic              grant_if_o,
  output logic              grant_data_o,
  input  logic              perf_clr_i,
  output logic [PERF_W-1:0] if_wait_cnt_o
);

  localparam int unsigned        StarveW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [PERF_W-1:0]  WaitMax   = '1;

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyData} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIf, OwnData} owner_e;

  state_e             state_q;
  owner_e             owner;
  logic [StarveW-1:0] starve_q;
  logic [PERF_W-1:0]  wait_q;

  // Ownership is combinational so a request seen in idle is granted in the same cycle.
  // Reset is folded in so every output reads as zero while reset is held.
  always_comb begin
    owner = OwnNone;
    if (rst_ni) begin
      unique case (state_q)
        StBusyIf:   owner = OwnIf;
        StBusyData: owner = OwnData;
        default: begin
          if (if_req_i.valid && data_req_i.valid) begin
            owner = (starve_q == StarveMax) ? OwnIf : OwnData;
          end else if (if_req_i.valid) begin
            owner = OwnIf;
          end else if (data_req_i.valid) begin
            owner = OwnData;
          end
        end
      endcase
    end
  end

  always_comb begin
    active_req_o = '0;
    if_resp_o    = '0;
    data_resp_o  = '0;
    unique case (owner)
      OwnIf: begin
        active_req_o = if_req_i;
        if_resp_o    = active_resp_i;
      end
      OwnData: begin
        active_req_o = data_req_i;
        data_resp_o  = active_resp_i;
      end
      default: ;
    endcase
  end

  assign grant_if_o    = (owner == OwnIf);
  assign grant_data_o  = (owner == OwnData);
  assign if_wait_cnt_o = wait_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (owner == OwnIf) begin
            starve_q <= '0;
            if (!active_resp_i.ready) state_q <= StBusyIf;
          end else if (owner == OwnData) begin
            // Only contested data wins count toward starving fetch.
            if (if_req_i.valid && (starve_q != StarveMax)) starve_q <= starve_q + 1'b1;
            if (!active_resp_i.ready) state_q <= StBusyData;
          end
        end
        StBusyIf: begin
          if (active_resp_i.ready || !if_req_i.valid) state_q <= StIdle;
        end
        StBusyData: begin
          if (active_resp_i.ready || !data_req_i.valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else if (perf_clr_i) begin
      wait_q <= '0;
    end else if (if_req_i.valid && (owner != OwnIf) && (wait_q != WaitMax)) begin
      wait_q <= wait_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_l1_port_scheduler.sv
// Bench for l1_port_scheduler: a table of per-cycle vectors feeds a scoreboard queue.
// Hand-written sequences cover reset and counter saturation.
module tb_l1_port_scheduler;
  import l1_port_scheduler_pkg::*;

  logic        clk;
  logic        rst_n;
  mem_req_t    if_req, data_req, active_req;
  mem_resp_t   if_resp, data_resp, active_resp;
  logic        grant_if, grant_data, perf_clr;
  logic [15:0] if_wait_cnt;

  l1_port_scheduler #(.STARVE_LIMIT(4), .PERF_W(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .if_req_i      (if_req),
    .if_resp_o     (if_resp),
    .data_req_i    (data_req),
    .data_resp_o   (data_resp),
    .active_req_o  (active_req),
    .active_resp_i (active_resp),
    .grant_if_o    (grant_if),
    .grant_data_o  (grant_data),
    .perf_clr_i    (perf_clr),
    .if_wait_cnt_o (if_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic ifv;
    logic dv;
    logic rdy;
    logic pc;
    logic gi;
    logic gd;
  } vec_t;

  typedef struct packed {
    logic        gi;
    logic        gd;
    mem_req_t    areq;
    mem_resp_t   ifr;
    mem_resp_t   dr;
    logic [15:0] wcnt;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_wait = '0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mem_req_t rand_req(input logic v);
    mem_req_t r;
    r.valid = v;
    r.we    = 1'($urandom);
    r.addr  = $urandom;
    r.wdata = $urandom;
    r.be    = 4'($urandom);
    return r;
  endfunction

  function automatic void add(input logic ifv, input logic dv, input logic rdy,
                              input logic pc, input logic gi, input logic gd);
    vec_t v;
    v.ifv = ifv; v.dv = dv; v.rdy = rdy; v.pc = pc; v.gi = gi; v.gd = gd;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected for that cycle.
  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    if_req            = rand_req(v.ifv);
    data_req          = rand_req(v.dv);
    active_resp.ready = v.rdy;
    active_resp.err   = 1'($urandom);
    active_resp.rdata = $urandom;
    perf_clr          = v.pc;
    e.gi   = v.gi;
    e.gd   = v.gd;
    e.areq = v.gi ? if_req : (v.gd ? data_req : '0);
    e.ifr  = v.gi ? active_resp : '0;
    e.dr   = v.gd ? active_resp : '0;
    e.wcnt = exp_wait;
    sb.push_back(e);
    if (v.pc) exp_wait = '0;
    else if (v.ifv && !v.gi && exp_wait != 16'hFFFF) exp_wait = exp_wait + 16'd1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk("grant_if", 96'(grant_if), 96'(cur.gi));
      chk("grant_data", 96'(grant_data), 96'(cur.gd));
      chk("active_req", 96'(active_req), 96'(cur.areq));
      chk("if_resp", 96'(if_resp), 96'(cur.ifr));
      chk("data_resp", 96'(data_resp), 96'(cur.dr));
      chk("if_wait_cnt", 96'(if_wait_cnt), 96'(cur.wcnt));
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    vec_t v;
    // IF only, L1 ready on the fourth cycle, then idle.
    add(1, 0, 0, 0, 1, 0); add(1, 0, 0, 0, 1, 0); add(1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 1, 0); add(0, 0, 0, 0, 0, 0);
    // Both valid, two-cycle transactions: D,D,D,D,I,D,D,D,D,I.
    for (int t = 0; t < 10; t++) begin
      add(1, 1, 0, 0, (t == 4 || t == 9), !(t == 4 || t == 9));
      add(1, 1, 1, 0, (t == 4 || t == 9), !(t == 4 || t == 9));
    end
    // Data arrives while IF is busy; IF keeps the port until its ready.
    add(1, 0, 0, 0, 1, 0);
    for (int t = 0; t < 4; t++) add(1, 1, 0, 0, 1, 0);
    add(1, 1, 1, 0, 1, 0); add(0, 1, 0, 0, 0, 1); add(0, 1, 1, 0, 0, 1);
    // Single-cycle hits on alternating requesters.
    add(1, 0, 1, 0, 1, 0); add(0, 1, 1, 0, 0, 1); add(1, 0, 1, 0, 1, 0); add(0, 1, 1, 0, 0, 1);
    // Data withdraws mid-transaction; pending IF is granted next.
    add(0, 1, 0, 0, 0, 1); add(1, 0, 0, 0, 0, 1); add(1, 0, 0, 0, 1, 0); add(1, 0, 1, 0, 1, 0);
    // perf_clr, including clear winning over a same-cycle increment.
    add(0, 0, 0, 1, 0, 0); add(0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 1); add(0, 0, 0, 0, 0, 0);

    // Reset held with both requesters valid and ready asserted.
    rst_n       = 1'b0;
    perf_clr    = 1'b0;
    if_req      = rand_req(1'b1);
    data_req    = rand_req(1'b1);
    active_resp = '{ready: 1'b1, err: 1'b1, rdata: 32'hA5A5_5A5A};
    #12;
    chk("rst_active_req", 96'(active_req), 96'(0));
    chk("rst_if_resp", 96'(if_resp), 96'(0));
    chk("rst_data_resp", 96'(data_resp), 96'(0));
    chk("rst_grants", 96'({grant_if, grant_data}), 96'(0));
    chk("rst_wait", 96'(if_wait_cnt), 96'(0));
    rst_n = 1'b1;
    #1;
    chk("rel_grant_data", 96'({grant_if, grant_data}), 96'(2'b01));
    chk("rel_active_req", 96'(active_req), 96'(data_req));
    chk("rel_data_resp", 96'(data_resp), 96'(active_resp));
    if_req.valid      = 1'b0;
    data_req.valid    = 1'b0;
    active_resp.ready = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // Data holds the port forever while fetch waits: counter must saturate.
    v = '{ifv: 1, dv: 1, rdy: 0, pc: 0, gi: 0, gd: 1};
    for (int i = 0; i < 65540; i++) step(v);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("wait_saturated", 96'(if_wait_cnt), 96'(16'hFFFF));
    chk("scoreboard_drained", 96'(sb.size()), 96'(0));

    // Asynchronous reset mid-transaction.
    #2;
    active_resp.ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_active_req", 96'(active_req), 96'(0));
    chk("midrst_resps", 96'({if_resp, data_resp}), 96'(0));
    chk("midrst_grants", 96'({grant_if, grant_data}), 96'(0));
    chk("midrst_wait", 96'(if_wait_cnt), 96'(0));
    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
